// File: rtl/scope_capture_ctrl.sv
// Oscilloscope capture/display sequencer: rising-edge trigger, two-bank record buffer, frame-synchronous swap.
// Optional build macro AUTO_TRIG_EN forces a trigger after TIMEOUT non-triggering samples in ARMED.
module scope_capture_ctrl #(
    parameter int unsigned WIDTH   = 640,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_in,
    input  logic       sample_valid,
    input  logic [7:0] sample_in,
    input  logic [7:0] trig_level_in,
    input  logic       frame_start_in,
    input  logic [9:0] x_in,
    output logic [7:0] data_out,
    output logic       triggered_out,
    output logic       busy_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam int unsigned       DEPTH     = 2 ** (ADDR_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH - 32'd1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);

    if ((WIDTH == 32'd0) || ((64'd1 << ADDR_W) < 64'(WIDTH)) || (TIMEOUT == 32'd0)) begin : g_param_check
        $error("scope_capture_ctrl: WIDTH must fit in 2^ADDR_W and TIMEOUT must be non-zero");
    end

`ifdef AUTO_TRIG_EN
    localparam int unsigned   TO_W     = $clog2(TIMEOUT + 32'd1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(32'd1);

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
`endif

    state_e            state_q,      state_d;
    logic              disp_bank_q,  disp_bank_d;
    logic              disp_valid_q, disp_valid_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [7:0]        prev_q,       prev_d;
    logic              prev_ok_q,    prev_ok_d;
    logic [7:0]        data_out_q,   data_out_d;
    logic              triggered_q,  triggered_d;
    logic              busy_q,       busy_d;

    logic              cross_s;
    logic              force_s;
    logic              trig_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_sel_s;
    logic [ADDR_W-1:0] rd_addr_s;

    logic [7:0]        mem_q [DEPTH];

    assign rd_addr_s = ADDR_W'(x_in);

    // Trigger qualification: a level crossing needs a valid previous sample from this arming.
    always_comb begin
        cross_s = sample_valid && prev_ok_q &&
                  (prev_q < trig_level_in) && (sample_in >= trig_level_in);
`ifdef AUTO_TRIG_EN
        force_s = sample_valid && (to_cnt_q == TO_LIMIT);
`else
        force_s = 1'b0;
`endif
        trig_s  = cross_s || force_s;
    end

    // Sequencer next-state, capture write control and bank swap.
    always_comb begin
        state_d      = state_q;
        disp_bank_d  = disp_bank_q;
        disp_valid_d = disp_valid_q;
        wr_addr_d    = wr_addr_q;
        prev_ok_d    = prev_ok_q;
        wr_en_s      = 1'b0;
        wr_sel_s     = wr_addr_q;
`ifdef AUTO_TRIG_EN
        to_cnt_d     = to_cnt_q;
`endif
        if (sample_valid) begin
            prev_d = sample_in;
        end else begin
            prev_d = prev_q;
        end

        case (state_q)
            S_IDLE: begin
                if (run_in) begin
                    state_d   = S_ARMED;
                    prev_ok_d = 1'b0;
`ifdef AUTO_TRIG_EN
                    to_cnt_d  = {TO_W{1'b0}};
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ARMED: begin
                // A trigger takes priority over run_in dropping in the same cycle.
                if (trig_s) begin
                    wr_en_s  = 1'b1;
                    wr_sel_s = {ADDR_W{1'b0}};
                    if (LAST_ADDR == {ADDR_W{1'b0}}) begin
                        state_d   = S_DONE;
                        wr_addr_d = {ADDR_W{1'b0}};
                    end else begin
                        state_d   = S_CAPTURE;
                        wr_addr_d = ADDR_ONE;
                    end
                end else begin
                    if (sample_valid) begin
                        prev_ok_d = 1'b1;
`ifdef AUTO_TRIG_EN
                        to_cnt_d  = to_cnt_q + TO_ONE;
`endif
                    end else begin
                        prev_ok_d = prev_ok_q;
                    end
                    if (!run_in) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end

            S_CAPTURE: begin
                if (sample_valid) begin
                    wr_en_s  = 1'b1;
                    wr_sel_s = wr_addr_q;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = S_DONE;
                        wr_addr_d = {ADDR_W{1'b0}};
                    end else begin
                        state_d   = S_CAPTURE;
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = S_CAPTURE;
                end
            end

            S_DONE: begin
                if (frame_start_in) begin
                    disp_bank_d  = ~disp_bank_q;
                    disp_valid_d = 1'b1;
                    if (run_in) begin
                        state_d   = S_ARMED;
                        prev_ok_d = 1'b0;
`ifdef AUTO_TRIG_EN
                        to_cnt_d  = {TO_W{1'b0}};
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, plus the blanked display read.
    always_comb begin
        triggered_d = (state_d == S_CAPTURE) || (state_d == S_DONE);
        busy_d      = (state_d == S_ARMED) || (state_d == S_CAPTURE);
        if (disp_valid_q && (32'(x_in) < WIDTH)) begin
            data_out_d = mem_q[{disp_bank_q, rd_addr_s}];
        end else begin
            data_out_d = 8'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            disp_bank_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            prev_q       <= 8'd0;
            prev_ok_q    <= 1'b0;
            data_out_q   <= 8'd0;
            triggered_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef AUTO_TRIG_EN
            to_cnt_q     <= {TO_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            disp_bank_q  <= disp_bank_d;
            disp_valid_q <= disp_valid_d;
            wr_addr_q    <= wr_addr_d;
            prev_q       <= prev_d;
            prev_ok_q    <= prev_ok_d;
            data_out_q   <= data_out_d;
            triggered_q  <= triggered_d;
            busy_q       <= busy_d;
`ifdef AUTO_TRIG_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    // Record buffer: writes always go to the bank not on display; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_q[{~disp_bank_q, wr_sel_s}] <= sample_in;
        end
    end

    assign data_out      = data_out_q;
    assign triggered_out = triggered_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Scoreboard bench for scope_capture_ctrl: directed stimulus pushes expected outputs, a monitor pops and compares.
module tb_scope_capture_ctrl;

    localparam int unsigned WIDTH   = 640;
    localparam int unsigned TIMEOUT = 16;
`ifdef AUTO_TRIG_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       run_in;
    logic       sample_valid;
    logic [7:0] sample_in;
    logic [7:0] trig_level_in;
    logic       frame_start_in;
    logic [9:0] x_in;
    logic [7:0] data_out;
    logic       triggered_out;
    logic       busy_out;

    logic [9:0] exp_q[$];
    string      name_q[$];
    logic       chk_req  = 1'b0;
    logic       chk_pend = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    scope_capture_ctrl #(.WIDTH(WIDTH), .ADDR_W(10), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .run_in         (run_in),
        .sample_valid   (sample_valid),
        .sample_in      (sample_in),
        .trig_level_in  (trig_level_in),
        .frame_start_in (frame_start_in),
        .x_in           (x_in),
        .data_out       (data_out),
        .triggered_out  (triggered_out),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    // A request raised with the inputs of cycle n is checked against outputs after edge n+1.
    initial forever begin
        @(posedge clk);
        chk_pend = chk_req;
    end

    initial begin
        logic [9:0] e;
        string      nm;
        forever begin
            @(negedge clk);
            if (chk_pend) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: output presented with no expected entry at %0t", $time);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    n_checks++;
                    if (data_out !== e[7:0]) begin
                        n_fail++;
                        $display("FAIL %s data_out: got %0d, expected %0d (t=%0t)", nm, data_out, e[7:0], $time);
                    end
                    n_checks++;
                    if (triggered_out !== e[9]) begin
                        n_fail++;
                        $display("FAIL %s triggered_out: got %0b, expected %0b (t=%0t)", nm, triggered_out, e[9], $time);
                    end
                    n_checks++;
                    if (busy_out !== e[8]) begin
                        n_fail++;
                        $display("FAIL %s busy_out: got %0b, expected %0b (t=%0t)", nm, busy_out, e[8], $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_req        = 1'b0;
        sample_valid   = 1'b0;
        frame_start_in = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] d, input logic t, input logic b);
        exp_q.push_back({t, b, d});
        name_q.push_back(nm);
        chk_req = 1'b1;
    endtask

    task automatic feed(input logic [7:0] s);
        sample_valid = 1'b1;
        sample_in    = s;
    endtask

    task automatic show(input string nm, input int x, input logic [7:0] d, input logic t, input logic b);
        x_in = 10'(x);
        expect_out(nm, d, t, b);
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        run_in         = 1'b0;
        sample_valid   = 1'b0;
        sample_in      = 8'd0;
        trig_level_in  = 8'd128;
        frame_start_in = 1'b0;
        x_in           = 10'd0;
        tick();
        expect_out("reset", 8'd0, 1'b0, 1'b0);
        tick();

        // Reset blanking and arming
        rst    = 1'b0;
        run_in = 1'b1;
        expect_out("arm_busy", 8'd0, 1'b0, 1'b1);
        tick();
        for (int x = 0; x < 800; x++) begin
            show("blank_sweep", x, 8'd0, 1'b0, 1'b1);
        end

        // Trigger on 130, capture a ramp, frame pulse mid-capture is ignored
        x_in = 10'd0;
        feed(8'd100); expect_out("pre_trig_100", 8'd0, 1'b0, 1'b1); tick();
        feed(8'd110); expect_out("pre_trig_110", 8'd0, 1'b0, 1'b1); tick();
        feed(8'd120); expect_out("pre_trig_120", 8'd0, 1'b0, 1'b1); tick();
        feed(8'd130); expect_out("trig_130", 8'd0, 1'b1, 1'b1); tick();
        for (int a = 1; a < 640; a++) begin
            if (a == 100) begin
                expect_out("capture_gap", 8'd0, 1'b1, 1'b1);
                tick();
            end
            feed(8'(130 + a));
            if (a == 300) begin
                frame_start_in = 1'b1;
                expect_out("fs_during_capture1", 8'd0, 1'b1, 1'b1);
            end
            if (a == 638) expect_out("capture_638", 8'd0, 1'b1, 1'b1);
            if (a == 639) expect_out("done1", 8'd0, 1'b1, 1'b0);
            tick();
        end
        feed(8'd255);
        expect_out("done_ignores_samples", 8'd0, 1'b1, 1'b0);
        tick();

        // Swap into display; read latency and out-of-range blanking
        frame_start_in = 1'b1;
        show("swap1", 0, 8'd0, 1'b0, 1'b1);
        show("disp1_x0", 0, 8'd130, 1'b0, 1'b1);
        show("disp1_x5", 5, 8'd135, 1'b0, 1'b1);
        show("disp1_x200", 200, 8'd74, 1'b0, 1'b1);
        show("disp1_x639", 639, 8'd1, 1'b0, 1'b1);
        show("disp1_x640", 640, 8'd0, 1'b0, 1'b1);
        show("disp1_x799", 799, 8'd0, 1'b0, 1'b1);

        // First sample after arming cannot trigger; run_in dropped mid-capture
        x_in = 10'd5;
        feed(8'd200); expect_out("first_no_trig", 8'd135, 1'b0, 1'b1); tick();
        feed(8'd50);  expect_out("below_level", 8'd135, 1'b0, 1'b1); tick();
        feed(8'd200); expect_out("trig_200", 8'd135, 1'b1, 1'b1); tick();
        for (int a = 1; a < 640; a++) begin
            feed(8'(a));
            if (a == 150) begin
                frame_start_in = 1'b1;
                expect_out("fs_during_capture2", 8'd135, 1'b1, 1'b1);
            end
            if (a == 151) expect_out("no_swap_mid_capture", 8'd135, 1'b1, 1'b1);
            if (a == 300) begin
                run_in = 1'b0;
                expect_out("runoff_continues", 8'd135, 1'b1, 1'b1);
            end
            if (a == 639) expect_out("done2", 8'd135, 1'b1, 1'b0);
            tick();
        end
        frame_start_in = 1'b1;
        show("swap2_to_idle", 5, 8'd135, 1'b0, 1'b0);
        show("disp2_x0", 0, 8'd200, 1'b0, 1'b0);
        show("disp2_x5", 5, 8'd5, 1'b0, 1'b0);
        show("disp2_x300", 300, 8'd44, 1'b0, 1'b0);
        show("disp2_x639", 639, 8'd127, 1'b0, 1'b0);
        show("disp2_x640", 640, 8'd0, 1'b0, 1'b0);

        // IDLE ignores samples; ARMED drops on run_in low; trigger beats run_in low
        x_in = 10'd5;
        feed(8'd0);   expect_out("idle_ignore_0", 8'd5, 1'b0, 1'b0); tick();
        feed(8'd200); expect_out("idle_ignore_200", 8'd5, 1'b0, 1'b0); tick();
        run_in = 1'b1; expect_out("arm2", 8'd5, 1'b0, 1'b1); tick();
        run_in = 1'b0; expect_out("armed_stop", 8'd5, 1'b0, 1'b0); tick();
        run_in = 1'b1; expect_out("arm3", 8'd5, 1'b0, 1'b1); tick();
        feed(8'd0); expect_out("arm3_first", 8'd5, 1'b0, 1'b1); tick();
        run_in = 1'b0;
        feed(8'd200); expect_out("trig_beats_runoff", 8'd5, 1'b1, 1'b1); tick();
        feed(8'd1); expect_out("capture3_a1", 8'd5, 1'b1, 1'b1); tick();

        // Reset mid-capture blanks the display
        rst = 1'b1;
        feed(8'd2); expect_out("rst_mid_capture", 8'd0, 1'b0, 1'b0); tick();
        rst = 1'b0;
        expect_out("post_rst_blank", 8'd0, 1'b0, 1'b0); tick();

        // Constant sub-level input: forced trigger only with the auto-trigger build
        run_in = 1'b1;
        expect_out("arm_auto", 8'd0, 1'b0, 1'b1); tick();
        for (int i = 1; i <= 16; i++) begin
            feed(8'd50);
            expect_out("auto_wait", 8'd0, 1'b0, 1'b1);
            tick();
        end
        feed(8'd50); expect_out("auto_17th", 8'd0, AUTO, 1'b1); tick();
        feed(8'd50); expect_out("auto_18th", 8'd0, AUTO, 1'b1); tick();

        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
